// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared state encoding, FP constants and index helpers for matrix_mult_mac
package matrix_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_ADD,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    function automatic int cnt_w(input int dim);
        return (dim > 2) ? $clog2(dim) : 1;
    endfunction

    function automatic int flat_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/fp_mac_step.sv
// rtl/fp_mac_step.sv - one acc + a*b step through the shared multiplier and adder handshakes
module fp_mac_step
    import matrix_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_acc,
    input  logic        i_go,
    output logic [31:0] o_sum,
    output logic        o_mul_done,
    output logic        o_done
);
    typedef enum logic [1:0] {P_IDLE, P_MUL, P_ADD} phase_t;

    phase_t      r_phase;
    logic [31:0] r_a, r_b, r_acc, r_prod;
    logic        r_a_stb, r_b_stb, r_z_ack, r_load, r_res_ack;
    logic        w_a_ack, w_b_ack, w_z_stb, w_res_ready;
    logic [31:0] w_z, w_result;

    multiplier u_mul (
        .clk(i_clk), .rst_n(i_rst_n),
        .input_a(r_a), .input_a_stb(r_a_stb), .input_a_ack(w_a_ack),
        .input_b(r_b), .input_b_stb(r_b_stb), .input_b_ack(w_b_ack),
        .output_z(w_z), .output_z_stb(w_z_stb), .output_z_ack(r_z_ack)
    );

    adder u_add (
        .clk(i_clk), .rst_n(i_rst_n),
        .load_a(r_acc), .load_b(r_prod), .load(r_load),
        .result(w_result), .result_ready(w_res_ready), .result_ack(r_res_ack)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= P_IDLE;
            r_a <= '0; r_b <= '0; r_acc <= FP_ZERO; r_prod <= FP_ZERO;
            r_a_stb <= 1'b0; r_b_stb <= 1'b0; r_z_ack <= 1'b0;
            r_load <= 1'b0; r_res_ack <= 1'b0;
            o_sum <= FP_ZERO; o_mul_done <= 1'b0; o_done <= 1'b0;
        end else begin
            r_z_ack    <= 1'b0;
            r_load     <= 1'b0;
            r_res_ack  <= 1'b0;
            o_mul_done <= 1'b0;
            o_done     <= 1'b0;
            case (r_phase)
                P_IDLE: if (i_go) begin
                    r_a <= i_a; r_b <= i_b; r_acc <= i_acc;
                    r_a_stb <= 1'b1; r_b_stb <= 1'b1;
                    r_phase <= P_MUL;
                end
                P_MUL: begin
                    if (w_a_ack) r_a_stb <= 1'b0;
                    if (w_b_ack) r_b_stb <= 1'b0;
                    if (w_z_stb) begin
                        r_prod     <= w_z;
                        r_z_ack    <= 1'b1;
                        r_load     <= 1'b1;
                        o_mul_done <= 1'b1;
                        r_phase    <= P_ADD;
                    end
                end
                P_ADD: if (w_res_ready) begin
                    o_sum     <= w_result;
                    r_res_ack <= 1'b1;
                    o_done    <= 1'b1;
                    r_phase   <= P_IDLE;
                end
                default: r_phase <= P_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/fp_units.sv
// rtl/fp_units.sv - shared IEEE-754 single multiplier and adder with strobe/ack handshakes
module multiplier
    import matrix_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    logic [31:0] r_a, r_b;
    logic        r_have_a, r_have_b;

    // Denormal inputs are flushed to signed zero; round to nearest even.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [24:0] m;
        logic        g, st;
        int          e;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'hFF && |a[22:0]) || (b[30:23] == 8'hFF && |b[22:0])) return FP_QNAN;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? FP_QNAN : {s, 8'hFF, 23'h0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 1;
        end else begin
            m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1; e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], m[22:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0; r_b <= '0; r_have_a <= 1'b0; r_have_b <= 1'b0;
            input_a_ack <= 1'b0; input_b_ack <= 1'b0;
            output_z <= '0; output_z_stb <= 1'b0;
        end else begin
            input_a_ack <= 1'b0;
            input_b_ack <= 1'b0;
            if (output_z_stb) begin
                if (output_z_ack) output_z_stb <= 1'b0;
            end else if (r_have_a && r_have_b) begin
                output_z     <= fp_mul(r_a, r_b);
                output_z_stb <= 1'b1;
                r_have_a     <= 1'b0;
                r_have_b     <= 1'b0;
            end else begin
                if (input_a_stb && !r_have_a) begin
                    r_a <= input_a; r_have_a <= 1'b1; input_a_ack <= 1'b1;
                end
                if (input_b_stb && !r_have_b) begin
                    r_b <= input_b; r_have_b <= 1'b1; input_b_ack <= 1'b1;
                end
            end
        end
    end
endmodule

module adder
    import matrix_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] load_a,
    input  logic [31:0] load_b,
    input  logic        load,
    output logic [31:0] result,
    output logic        result_ready,
    input  logic        result_ack
);
    // Three guard bits plus sticky; exact cancellation yields +0.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [26:0] ma, mb, sh;
        logic [27:0] s;
        logic [24:0] m;
        logic        g, st;
        int          e, d, lz;
        if ((x[30:23] == 8'hFF && |x[22:0]) || (y[30:23] == 8'hFF && |y[22:0])) return FP_QNAN;
        if (x[30:23] == 8'hFF && y[30:23] == 8'hFF) return (x[31] != y[31]) ? FP_QNAN : x;
        if (x[30:23] == 8'hFF) return x;
        if (y[30:23] == 8'hFF) return y;
        if (x[30:23] == 8'h00 && y[30:23] == 8'h00) return {x[31] & y[31], 31'h0};
        if (x[30:23] == 8'h00) return y;
        if (y[30:23] == 8'h00) return x;
        if (x[30:0] >= y[30:0]) begin
            a = x; b = y;
        end else begin
            a = y; b = x;
        end
        ma = {1'b1, a[22:0], 3'b000};
        mb = {1'b1, b[22:0], 3'b000};
        e  = int'(a[30:23]);
        d  = e - int'(b[30:23]);
        if (d > 26) begin
            sh = 27'd1;
        end else begin
            sh = mb >> d;
            if ((mb & ((27'd1 << d) - 27'd1)) != 27'd0) sh[0] = 1'b1;
        end
        if (a[31] == b[31]) s = {1'b0, ma} + {1'b0, sh};
        else                s = {1'b0, ma} - {1'b0, sh};
        if (s == 28'd0) return FP_ZERO;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            lz = 0;
            for (int i = 0; i < 27; i++) if (s[i]) lz = 26 - i;
            s = s << lz;
            e = e - lz;
        end
        m  = {1'b0, s[26:3]};
        g  = s[2];
        st = |s[1:0];
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1; e = e + 1;
        end
        if (e >= 255) return {a[31], 8'hFF, 23'h0};
        if (e <= 0) return {a[31], 31'h0};
        return {a[31], e[7:0], m[22:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            result_ready <= 1'b0;
        end else if (result_ready) begin
            if (result_ack) result_ready <= 1'b0;
        end else if (load) begin
            result       <= fp_add(load_a, load_b);
            result_ready <= 1'b1;
        end
    end
endmodule

// File: rtl/matrix_mult_mac.sv
// rtl/matrix_mult_mac.sv - sequential FP matrix multiply C = A*B, one MAC at a time
// Optional MATMUL_ACCUM_EN adds in_matrix_c_init/in_accumulate for C = A*B + C_init.
module matrix_mult_mac
    import matrix_pkg::*;
#(
    parameter int ROWS_A = 2,
    parameter int INNER  = 2,
    parameter int COLS_B = 2,
    parameter int WIDTH  = 32
) (
    input  logic                              in_clk,
    input  logic                              in_reset,
    input  logic                              in_ready,
    input  logic [ROWS_A*INNER*WIDTH-1:0]     in_matrix_a,
    input  logic [INNER*COLS_B*WIDTH-1:0]     in_matrix_b,
`ifdef MATMUL_ACCUM_EN
    input  logic [ROWS_A*COLS_B*WIDTH-1:0]    in_matrix_c_init,
    input  logic                              in_accumulate,
`endif
    input  logic                              in_result_ack,
    output logic [ROWS_A*COLS_B*WIDTH-1:0]    out_matrix_c,
    output logic                              out_ready,
    output logic                              out_busy
);
    localparam int IW = cnt_w(ROWS_A);
    localparam int JW = cnt_w(COLS_B);
    localparam int KW = cnt_w(INNER);
    localparam logic [IW-1:0] I_LAST = IW'(ROWS_A - 1);
    localparam logic [JW-1:0] J_LAST = JW'(COLS_B - 1);
    localparam logic [KW-1:0] K_LAST = KW'(INNER - 1);

    state_t                          r_state;
    logic [IW-1:0]                   r_i;
    logic [JW-1:0]                   r_j;
    logic [KW-1:0]                   r_k;
    logic [WIDTH-1:0]                r_acc;
    logic [ROWS_A*INNER*WIDTH-1:0]   r_a;
    logic [INNER*COLS_B*WIDTH-1:0]   r_b;
    logic [ROWS_A*COLS_B*WIDTH-1:0]  r_c;
    logic                            r_ready, r_busy, r_go;
`ifdef MATMUL_ACCUM_EN
    logic [ROWS_A*COLS_B*WIDTH-1:0]  r_cinit;
    logic                            r_accum;
    int                              w_next_idx;
`endif

    logic [WIDTH-1:0] w_a_elem, w_b_elem, w_sum, w_seed_load, w_seed_next;
    logic             w_mul_done, w_done, w_last_i, w_last_j;
    logic [IW-1:0]    w_next_i;
    logic [JW-1:0]    w_next_j;
    int               w_c_idx;

    assign out_matrix_c = r_c;
    assign out_ready    = r_ready;
    assign out_busy     = r_busy;

    // Operand select plus the row-major successor cell and its accumulator seed.
    always_comb begin
        w_a_elem    = r_a[flat_idx(int'(r_i), int'(r_k), INNER) * WIDTH +: WIDTH];
        w_b_elem    = r_b[flat_idx(int'(r_k), int'(r_j), COLS_B) * WIDTH +: WIDTH];
        w_c_idx     = flat_idx(int'(r_i), int'(r_j), COLS_B);
        w_last_i    = (r_i == I_LAST);
        w_last_j    = (r_j == J_LAST);
        w_next_i    = w_last_j ? r_i + IW'(1) : r_i;
        w_next_j    = w_last_j ? '0 : r_j + JW'(1);
        w_seed_load = FP_ZERO;
        w_seed_next = FP_ZERO;
`ifdef MATMUL_ACCUM_EN
        w_next_idx  = (w_last_i && w_last_j) ? 0 : flat_idx(int'(w_next_i), int'(w_next_j), COLS_B);
        if (r_accum) begin
            w_seed_load = r_cinit[0 +: WIDTH];
            w_seed_next = r_cinit[w_next_idx * WIDTH +: WIDTH];
        end
`endif
    end

    fp_mac_step u_mac (
        .i_clk(in_clk), .i_rst_n(in_reset),
        .i_a(w_a_elem), .i_b(w_b_elem), .i_acc(r_acc), .i_go(r_go),
        .o_sum(w_sum), .o_mul_done(w_mul_done), .o_done(w_done)
    );

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state <= S_IDLE;
            r_i <= '0; r_j <= '0; r_k <= '0;
            r_acc <= FP_ZERO; r_a <= '0; r_b <= '0; r_c <= '0;
            r_ready <= 1'b0; r_busy <= 1'b0; r_go <= 1'b0;
`ifdef MATMUL_ACCUM_EN
            r_cinit <= '0; r_accum <= 1'b0;
`endif
        end else begin
            r_go <= 1'b0;
            case (r_state)
                S_IDLE: if (in_ready) begin
                    r_a <= in_matrix_a;
                    r_b <= in_matrix_b;
`ifdef MATMUL_ACCUM_EN
                    r_cinit <= in_matrix_c_init;
                    r_accum <= in_accumulate;
`endif
                    r_busy  <= 1'b1;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_acc <= w_seed_load;
                    r_i <= '0; r_j <= '0; r_k <= '0;
                    r_go <= 1'b1;
                    r_state <= S_MUL;
                end
                S_MUL: if (w_mul_done) r_state <= S_ADD;
                S_ADD: if (w_done) begin
                    r_acc <= w_sum;
                    if (r_k == K_LAST) begin
                        r_state <= S_STORE;
                    end else begin
                        r_k <= r_k + KW'(1);
                        r_go <= 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_STORE: begin
                    r_c[w_c_idx * WIDTH +: WIDTH] <= r_acc;
                    r_k <= '0;
                    if (w_last_i && w_last_j) begin
                        r_acc   <= FP_ZERO;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i <= w_next_i;
                        r_j <= w_next_j;
                        r_acc <= w_seed_next;
                        r_go <= 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_DONE: if (in_result_ack) begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mult_mac.sv
// tb/tb_matrix_mult_mac.sv - scoreboard bench for matrix_mult_mac (2x2x2 and 2x3x1 instances)
module tb_matrix_mult_mac;
    import matrix_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         ready1, ack1, o_ready1, o_busy1;
    logic [127:0] a1, b1, c1;
    logic         ready2, ack2, o_ready2, o_busy2;
    logic [191:0] a2;
    logic [95:0]  b2;
    logic [63:0]  c2;
`ifdef MATMUL_ACCUM_EN
    logic [127:0] cinit1;
    logic         accum1;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int n_mul2  = 0;
    int n_add2  = 0;
    logic [127:0] sb1[$];
    logic [63:0]  sb2[$];
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;

    matrix_mult_mac #(.ROWS_A(2), .INNER(2), .COLS_B(2), .WIDTH(32)) dut (
        .in_clk(clk), .in_reset(rst_n), .in_ready(ready1),
        .in_matrix_a(a1), .in_matrix_b(b1),
`ifdef MATMUL_ACCUM_EN
        .in_matrix_c_init(cinit1), .in_accumulate(accum1),
`endif
        .in_result_ack(ack1), .out_matrix_c(c1), .out_ready(o_ready1), .out_busy(o_busy1)
    );

    matrix_mult_mac #(.ROWS_A(2), .INNER(3), .COLS_B(1), .WIDTH(32)) dut2 (
        .in_clk(clk), .in_reset(rst_n), .in_ready(ready2),
        .in_matrix_a(a2), .in_matrix_b(b2),
`ifdef MATMUL_ACCUM_EN
        .in_matrix_c_init(64'h0), .in_accumulate(1'b0),
`endif
        .in_result_ack(ack2), .out_matrix_c(c2), .out_ready(o_ready2), .out_busy(o_busy2)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Monitors: pop and compare on each rising edge of out_ready.
    initial forever begin
        @(negedge clk);
        if (o_ready1 && !prev1) begin
            check("dut1_result_expected", 128'(sb1.size() != 0), 128'(1));
            if (sb1.size() != 0) check("dut1_result", c1, sb1.pop_front());
        end
        prev1 = o_ready1;
    end

    initial forever begin
        @(negedge clk);
        if (o_ready2 && !prev2) begin
            check("dut2_result_expected", 128'(sb2.size() != 0), 128'(1));
            if (sb2.size() != 0) check("dut2_result", 128'(c2), 128'(sb2.pop_front()));
        end
        prev2 = o_ready2;
    end

    always @(negedge clk) begin
        if (dut2.u_mac.w_z_stb && dut2.u_mac.r_z_ack) n_mul2++;
        if (dut2.u_mac.w_res_ready && dut2.u_mac.r_res_ack) n_add2++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start1(input logic [127:0] a, input logic [127:0] b,
                          input logic [127:0] exp, input bit push);
        a1 = a; b1 = b;
        if (push) sb1.push_back(exp);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check("busy_after_start", 128'(o_busy1), 128'(1));
    endtask

    task automatic wait_ready1(input string name);
        int n = 0;
        while (!o_ready1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready1) begin
            n_total++;
            $display("FAIL %s_timeout: out_ready=0 required 1", name);
        end
    endtask

    task automatic finish1(input string name);
        wait_ready1(name);
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
        check({name, "_released"}, 128'(o_ready1), 128'(0));
    endtask

    localparam logic [127:0] A_ID  = {32'h3F800000, 32'h0, 32'h0, 32'h3F800000};
    localparam logic [127:0] M1234 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] SQ    = {32'h41B00000, 32'h41700000, 32'h41200000, 32'h40E00000};
    localparam logic [127:0] B_PM  = {32'h3F800000, 32'hBF800000, 32'hBF800000, 32'h3F800000};
    localparam logic [127:0] C_PM  = {32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000};
    localparam logic [127:0] B_NEG = {4{32'hBF800000}};
    localparam logic [127:0] A_FR  = {32'h3F800000, 32'hC0000000, 32'h3FC00000, 32'h3F000000};

    initial begin
        int n, m0, d0;
        logic stable;
        rst_n = 1'b0; ready1 = 1'b0; ack1 = 1'b0; a1 = '0; b1 = '0;
        ready2 = 1'b0; ack2 = 1'b0; a2 = '0; b2 = '0;
`ifdef MATMUL_ACCUM_EN
        cinit1 = '0; accum1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_ready", 128'(o_ready1), 128'(0));
        check("reset_busy", 128'(o_busy1), 128'(0));
        check("reset_c", c1, 128'(0));
        check("reset_c2", 128'(c2), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        start1(A_ID, M1234, M1234, 1'b1);   finish1("t1_identity");
        start1(M1234, M1234, SQ, 1'b1);     finish1("t_square");
        start1(M1234, B_PM, C_PM, 1'b1);    finish1("t_signed");
        start1(128'h0, B_NEG, 128'h0, 1'b1); finish1("t_negzero");
        start1(A_FR, A_ID, A_FR, 1'b1);     finish1("t_fraction");

        // 2x3 times 3x1 of ones: row sums 6 and 15.
        a2 = {32'h40C00000, 32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        b2 = {3{32'h3F800000}};
        sb2.push_back({32'h41700000, 32'h40C00000});
        m0 = n_mul2; d0 = n_add2;
        ready2 = 1'b1; @(negedge clk); ready2 = 1'b0;
        n = 0;
        while (!o_ready2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready2) begin
            n_total++;
            $display("FAIL t2_timeout: out_ready=0 required 1");
        end
        ack2 = 1'b1; @(negedge clk); ack2 = 1'b0;
        check("t2_mul_handshakes", 128'(n_mul2 - m0), 128'(6));
        check("t2_add_handshakes", 128'(n_add2 - d0), 128'(6));

        // Result held without ack; ack together with start does not restart.
        start1(M1234, M1234, SQ, 1'b1);
        wait_ready1("t3_hold");
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!o_ready1 || c1 !== SQ) stable = 1'b0;
        end
        check("t3_hold_stable", 128'(stable), 128'(1));
        ack1 = 1'b1; ready1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0; ready1 = 1'b0;
        check("t3_ready_after_ack", 128'(o_ready1), 128'(0));
        check("t3_busy_after_ack", 128'(o_busy1), 128'(0));
        @(negedge clk);
        check("t3_no_start_in_done", 128'(o_busy1), 128'(0));

        // Start strobes while busy are ignored.
        start1(A_ID, M1234, M1234, 1'b1);
        repeat (4) begin
            repeat (3) @(negedge clk);
            ready1 = 1'b1;
            @(negedge clk);
            ready1 = 1'b0;
        end
        finish1("t5_busy_pulses");
        repeat (5) @(negedge clk);
        check("t5_idle_after", 128'(o_busy1), 128'(0));
        check("t5_single_result", 128'(sb1.size()), 128'(0));

        // Reset during S_ADD of the second row, then a clean rerun.
        start1(M1234, M1234, SQ, 1'b0);
        n = 0;
        while (!(dut.r_state == S_ADD && dut.r_i == 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t4_partial_row0", 128'(c1[63:0]), 128'({32'h41200000, 32'h40E00000}));
        rst_n = 1'b0;
        #1;
        check("t4_reset_ready", 128'(o_ready1), 128'(0));
        check("t4_reset_busy", 128'(o_busy1), 128'(0));
        check("t4_reset_c", c1, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start1(M1234, M1234, SQ, 1'b1);
        finish1("t4_rerun");

`ifdef MATMUL_ACCUM_EN
        cinit1 = {4{32'h3F800000}};
        accum1 = 1'b1;
        start1(A_ID, M1234, {32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000}, 1'b1);
        accum1 = 1'b0;
        finish1("t6_accumulate");
`endif

        repeat (5) @(negedge clk);
        check("sb1_drained", 128'(sb1.size()), 128'(0));
        check("sb2_drained", 128'(sb2.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
